// File: rtl/mac_requant_drain_if.sv
// Stream bundle for mac_requant_drain: partial sums in, quantized activations out.
// The design side uses the slave modport and the producer/consumer side uses master.
interface mac_requant_drain_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/mac_requant_drain.sv
// Accumulates MAC-array partial sums per output element, then requantizes each
// group to int8, int4 or binary and hands the result to the activation buffer.
//
// state   | meaning
// S_ACCUM | accepting partials, adding them onto the bias
// S_MUL   | multiplying the accumulator by the requant scale
// S_RND   | round, shift, zero-point add and clip; register the result
// S_OUT   | holding the result until the downstream takes it
module mac_requant_drain #(
  parameter int ACC_W   = 40,
  parameter int LEN_W   = 16,
  parameter int SCALE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         prec,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [31:0]        cfg_bias,
  input  logic [SCALE_W-1:0] cfg_scale,
  input  logic [5:0]         cfg_shift,
  input  logic [7:0]         cfg_zp,
  mac_requant_drain_if.slave bus,
  output logic               busy
);

  localparam int PROD_W = ACC_W + SCALE_W + 1;
  // Wide enough to hold prod plus a rounding constant of 2^62.
  localparam int RND_W  = PROD_W + 16;

  typedef enum logic [1:0] {S_ACCUM, S_MUL, S_RND, S_OUT} state_t;

  state_t                     state_q, state_d;
  logic [LEN_W-1:0]           cnt_q, cnt_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [PROD_W-1:0]   prod_q, prod_d;
  logic [1:0]                 prec_q, prec_d;
  logic [SCALE_W-1:0]         scale_q, scale_d;
  logic [5:0]                 shift_q, shift_d;
  logic [7:0]                 zp_q, zp_d;
  logic [7:0]                 out_data_q, out_data_d;
  logic                       out_sat_q, out_sat_d;
  logic                       out_valid_q, out_valid_d;

  logic [LEN_W-1:0]           len_now;
  logic signed [ACC_W-1:0]    data_x, bias_x;
  logic signed [PROD_W-1:0]   acc_x, scl_x;
  logic signed [RND_W-1:0]    prod_x, half_c, r_c, y_c, hi_c, lo_c;
  logic [7:0]                 hi8, lo8;

  assign data_x = {{(ACC_W-32){bus.in_data[31]}}, bus.in_data};
  assign bias_x = {{(ACC_W-32){cfg_bias[31]}}, cfg_bias};
  assign acc_x  = {{(SCALE_W+1){acc_q[ACC_W-1]}}, acc_q};
  assign scl_x  = {{(ACC_W+1){1'b0}}, scale_q};
  assign prod_x = {{(RND_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

  always_comb begin
    half_c = '0;
    if (shift_q != 6'd0) half_c = {{(RND_W-1){1'b0}}, 1'b1} << (shift_q - 6'd1);
    r_c = (prod_x + half_c) >>> shift_q;
    y_c = r_c + {{(RND_W-8){zp_q[7]}}, zp_q};
    if (prec_q == 2'b01) begin
      hi_c = RND_W'(7);
      lo_c = -RND_W'(8);
      hi8  = 8'h07;
      lo8  = 8'hF8;
    end else begin
      hi_c = RND_W'(127);
      lo_c = -RND_W'(128);
      hi8  = 8'h7F;
      lo8  = 8'h80;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    prec_d      = prec_q;
    scale_d     = scale_q;
    shift_d     = shift_q;
    zp_d        = zp_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    len_now     = len_q;
    case (state_q)
      S_ACCUM: begin
        if (bus.in_valid) begin
          if (cnt_q == '0) begin
            len_now = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
            len_d   = len_now;
            prec_d  = prec;
            scale_d = cfg_scale;
            shift_d = cfg_shift;
            zp_d    = cfg_zp;
            acc_d   = bias_x + data_x;
          end else begin
            acc_d   = acc_q + data_x;
          end
          if (cnt_q + LEN_W'(1) == len_now) begin
            cnt_d   = '0;
            state_d = S_MUL;
          end else begin
            cnt_d   = cnt_q + LEN_W'(1);
          end
        end
      end
      S_MUL: begin
        prod_d  = acc_x * scl_x;
        state_d = S_RND;
      end
      S_RND: begin
        if (prec_q == 2'b10) begin
          out_data_d = {7'b0, ~r_c[RND_W-1]};
          out_sat_d  = 1'b0;
        end else if (y_c > hi_c) begin
          out_data_d = hi8;
          out_sat_d  = 1'b1;
        end else if (y_c < lo_c) begin
          out_data_d = lo8;
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = y_c[7:0];
          out_sat_d  = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_ACCUM;
        end
      end
      default: state_d = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ACCUM;
      cnt_q       <= '0;
      len_q       <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      prec_q      <= '0;
      scale_q     <= '0;
      shift_q     <= '0;
      zp_q        <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      prec_q      <= prec_d;
      scale_q     <= scale_d;
      shift_q     <= shift_d;
      zp_q        <= zp_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == S_ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign busy          = (state_q != S_ACCUM) || (cnt_q != '0);

endmodule

// File: tb/tb_mac_requant_drain.sv
// Bench for mac_requant_drain: directed vector table, reset and backpressure
// sequences, then random groups checked against an arithmetic reference model.
module tb_mac_requant_drain;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  prec;
  logic [15:0] cfg_len;
  logic [31:0] cfg_bias;
  logic [15:0] cfg_scale;
  logic [5:0]  cfg_shift;
  logic [7:0]  cfg_zp;
  logic        busy;

  mac_requant_drain_if bus();

  mac_requant_drain dut (
    .clk(clk), .rst(rst), .prec(prec), .cfg_len(cfg_len), .cfg_bias(cfg_bias),
    .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
    .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  prec;
    logic [15:0] len;
    logic [31:0] bias;
    logic [15:0] scale;
    logic [5:0]  shift;
    logic [7:0]  zp;
    logic [31:0] p [4];
    int          stall;
    logic [7:0]  exp_d;
    logic        exp_s;
  } grp_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic grp_t mk(input logic [1:0] pr, input int len, input int bias,
                              input int scale, input int shift, input int zp,
                              input int p0, input int p1, input int p2,
                              input int ed, input int es, input int stall);
    grp_t g;
    g.prec  = pr;
    g.len   = 16'(len);
    g.bias  = bias;
    g.scale = 16'(scale);
    g.shift = 6'(shift);
    g.zp    = 8'(zp);
    g.p[0]  = p0;
    g.p[1]  = p1;
    g.p[2]  = p2;
    g.p[3]  = 0;
    g.exp_d = 8'(ed);
    g.exp_s = es[0];
    g.stall = stall;
    return g;
  endfunction

  // Reference: plain integer arithmetic on the group's rules.
  function automatic void model(input grp_t g, output logic [7:0] d, output logic s);
    longint acc, prod, r, y, lo, hi;
    int n;
    n = (g.len == 0) ? 1 : int'(g.len);
    acc = longint'($signed(g.bias));
    for (int i = 0; i < n; i++) acc += longint'($signed(g.p[i]));
    acc = (acc <<< 24) >>> 24;
    prod = acc * longint'(g.scale);
    if (g.shift == 0) r = prod;
    else r = (prod + (longint'(1) <<< (g.shift - 1))) >>> g.shift;
    if (g.prec == 2'b10) begin
      d = (r >= 0) ? 8'd1 : 8'd0;
      s = 1'b0;
    end else begin
      if (g.prec == 2'b01) begin lo = -8; hi = 7; end
      else begin lo = -128; hi = 127; end
      y = r + longint'($signed(g.zp));
      s = 1'b0;
      if (y > hi) begin y = hi; s = 1'b1; end
      if (y < lo) begin y = lo; s = 1'b1; end
      d = y[7:0];
    end
  endfunction

  task automatic scramble_cfg();
    prec      = 2'($urandom);
    cfg_len   = 16'($urandom);
    cfg_bias  = $urandom;
    cfg_scale = 16'($urandom);
    cfg_shift = 6'($urandom);
    cfg_zp    = 8'($urandom);
  endtask

  task automatic run_group(input grp_t g, input string tag);
    int n;
    int w;
    n = (g.len == 0) ? 1 : int'(g.len);
    @(negedge clk);
    prec = g.prec; cfg_len = g.len; cfg_bias = g.bias;
    cfg_scale = g.scale; cfg_shift = g.shift; cfg_zp = g.zp;
    bus.out_ready = (g.stall == 0);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = g.p[i];
      w = 0;
      while (!bus.in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (w >= 20) chk({tag, " in_ready_timeout"}, 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (i == 0) scramble_cfg();
      if (i < n - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    chk({tag, " mul_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, " mul_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " mul_busy"}, 64'(busy), 64'd1);
    @(negedge clk);
    chk({tag, " rnd_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, " rnd_out_valid"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk({tag, " latency_out_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, " out_data"}, 64'(bus.out_data), 64'(g.exp_d));
    chk({tag, " out_sat"}, 64'(bus.out_sat), 64'(g.exp_s));
    for (int s = 0; s < g.stall; s++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      scramble_cfg();
      @(negedge clk);
      chk({tag, " stall_out_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, " stall_out_data"}, 64'(bus.out_data), 64'(g.exp_d));
      chk({tag, " stall_out_sat"}, 64'(bus.out_sat), 64'(g.exp_s));
      chk({tag, " stall_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " drain_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " drain_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, " drain_busy"}, 64'(busy), 64'd0);
  endtask

  grp_t tbl[$];
  grp_t g;
  logic [7:0] md;
  logic ms;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    prec = '0; cfg_len = '0; cfg_bias = '0; cfg_scale = '0; cfg_shift = '0; cfg_zp = '0;

    //       prec   len bias scale sh  zp    p0    p1  p2  exp   sat stall
    tbl.push_back(mk(2'b00, 3, 0,  1, 0,   0,   10,   20, -5, 8'h19, 0, 0));
    tbl.push_back(mk(2'b00, 1, 0,  3, 2,   0,    5,    0,  0, 8'h04, 0, 0));
    tbl.push_back(mk(2'b00, 1, 0,  3, 2,   0,   -5,    0,  0, 8'hFC, 0, 0));
    tbl.push_back(mk(2'b00, 1, 7,  1, 1,   0,    0,    0,  0, 8'h04, 0, 0));
    tbl.push_back(mk(2'b00, 1, 0,  1, 0,  10,  120,    0,  0, 8'h7F, 1, 0));
    tbl.push_back(mk(2'b00, 1, 0,  1, 0,   0, -200,    0,  0, 8'h80, 1, 0));
    tbl.push_back(mk(2'b00, 1, 0,  1, 0,   0,  127,    0,  0, 8'h7F, 0, 0));
    tbl.push_back(mk(2'b01, 1, 0,  1, 0,   0,  100,    0,  0, 8'h07, 1, 0));
    tbl.push_back(mk(2'b01, 1, 0,  1, 0,   0, -100,    0,  0, 8'hF8, 1, 0));
    tbl.push_back(mk(2'b01, 1, 0,  1, 0,   0,    3,    0,  0, 8'h03, 0, 0));
    tbl.push_back(mk(2'b01, 1, 0,  1, 0,   1,    7,    0,  0, 8'h07, 1, 0));
    tbl.push_back(mk(2'b10, 0, 0,  1, 0,   0,   -1,    0,  0, 8'h00, 0, 0));
    tbl.push_back(mk(2'b10, 0, 0,  1, 0, -100,   0,    0,  0, 8'h01, 0, 0));
    tbl.push_back(mk(2'b10, 0, -3, 1, 0,   0,    0,    0,  0, 8'h00, 0, 0));
    tbl.push_back(mk(2'b11, 1, 0,  1, 0,   0,   -7,    0,  0, 8'hF9, 0, 0));
    tbl.push_back(mk(2'b00, 2, 0,  1, 0,   0,   40,    2,  0, 8'h2A, 0, 5));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset out_data", 64'(bus.out_data), 64'd0);
    chk("reset out_sat", 64'(bus.out_sat), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);

    for (int i = 0; i < tbl.size(); i++) run_group(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a len=4 group throws the partial work away.
    @(negedge clk);
    prec = 2'b00; cfg_len = 16'd4; cfg_bias = 32'd0; cfg_scale = 16'd1;
    cfg_shift = 6'd0; cfg_zp = 8'd0;
    bus.in_valid = 1'b1; bus.in_data = 32'd1000;
    @(negedge clk);
    bus.in_data = 32'd2000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("midgrp busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midgrp rst busy", 64'(busy), 64'd0);
    chk("midgrp rst in_ready", 64'(bus.in_ready), 64'd1);
    chk("midgrp rst out_data", 64'(bus.out_data), 64'd0);
    repeat (6) @(negedge clk);
    chk("midgrp no out_valid", 64'(bus.out_valid), 64'd0);
    run_group(mk(2'b00, 1, 0, 1, 0, 0, 9, 0, 0, 8'h09, 0, 0), "post_reset");

    for (int k = 0; k < 60; k++) begin
      g.prec  = 2'($urandom);
      g.len   = 16'($urandom_range(0, 4));
      g.bias  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 400)) - 32'd200;
      g.scale = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8));
      g.shift = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'($urandom_range(0, 6));
      g.zp    = 8'($urandom);
      for (int j = 0; j < 4; j++)
        g.p[j] = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 600)) - 32'd300;
      g.stall = $urandom_range(0, 3);
      model(g, md, ms);
      g.exp_d = md;
      g.exp_s = ms;
      run_group(g, $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
